// File: rtl/x_top_mem_link_pkg.sv
// Shared definitions for the UART memory link: command encodings, acknowledge
// byte, packet byte counts and the target-side state enum.
package x_top_mem_link_pkg;

    localparam logic [7:0] CMD_WR = 8'h00;
    localparam logic [7:0] CMD_RD = 8'h01;
    localparam logic [7:0] ACK    = 8'hA5;

    localparam int CMD_BYTES     = 1;
    localparam int ADDR_BYTES    = 4;
    localparam int DATA_BYTES    = 4;
    localparam int RD_RESP_BYTES = 4;
    localparam int WR_RESP_BYTES = 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        MEM  = 3'd3,
        RESP = 3'd4
    } state_t;

endpackage

// File: rtl/x_top_mem_target_timeout.sv
// Inter-byte timeout: reloads on clear, counts down while enabled and flags
// expiry on the last counted cycle, independent of a same-cycle clear.
module x_top_mem_target_timeout #(
    parameter int p_count = 3125
) (
    input  logic i_clk,
    input  logic i_nrst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int W = $clog2(p_count + 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            cnt_q <= '0;
        end else if (i_clr) begin
            cnt_q <= W'(p_count);
        end else if (i_en && cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign o_expire = i_en && (cnt_q == W'(1));

endmodule

// File: rtl/x_top_mem_target.sv
// Remote end of the UART memory link: parses request packets from UART bytes,
// performs one 32-bit access on the memory bus and returns data or an ack.
module x_top_mem_target
    import x_top_mem_link_pkg::*;
#(
    parameter int p_clk_hz  = 1000000,
    parameter int p_baud    = 9600,
    parameter int p_timeout = 3 * 10 * p_clk_hz / p_baud
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_uart_valid,
    input  logic [7:0]  i_uart_data,
    output logic        o_uart_valid,
    output logic [7:0]  o_uart_data,
    input  logic        i_uart_accept,
    output logic        o_mem_valid,
    output logic        o_mem_rnw,
    input  logic        i_mem_accept,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_data,
    input  logic [31:0] i_mem_data,
    output logic        o_err
);

    localparam logic [1:0] ADDR_LAST    = 2'(ADDR_BYTES - 1);
    localparam logic [1:0] DATA_LAST    = 2'(DATA_BYTES - 1);
    localparam logic [1:0] RD_RESP_LAST = 2'(RD_RESP_BYTES - 1);
    localparam logic [1:0] WR_RESP_LAST = 2'(WR_RESP_BYTES - 1);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        rnw_q;
    logic [31:0] addr_q, data_q, resp_q;
    logic        err_q, err_d;
    logic        rnw_we, addr_we, data_we, resp_we;
    logic        in_packet, expire;

    assign in_packet = (state_q == ADDR) || (state_q == DATA);

    // Any received byte restarts the timeout; outside a packet it stays loaded
    x_top_mem_target_timeout #(
        .p_count (p_timeout)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_nrst   (i_nrst),
        .i_clr    (i_uart_valid || !in_packet),
        .i_en     (in_packet),
        .o_expire (expire)
    );

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            resp_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            if (rnw_we)  rnw_q <= i_uart_data[0];
            if (addr_we) addr_q[{idx_q, 3'b000} +: 8] <= i_uart_data;
            if (data_we) data_q[{idx_q, 3'b000} +: 8] <= i_uart_data;
            if (resp_we) resp_q <= i_mem_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        err_d        = 1'b0;
        rnw_we       = 1'b0;
        addr_we      = 1'b0;
        data_we      = 1'b0;
        resp_we      = 1'b0;
        o_mem_valid  = 1'b0;
        o_uart_valid = 1'b0;
        o_uart_data  = 8'h00;

        unique case (state_q)
            IDLE: begin
                if (i_uart_valid) begin
                    if (i_uart_data == CMD_WR || i_uart_data == CMD_RD) begin
                        rnw_we  = 1'b1;
                        idx_d   = '0;
                        state_d = ADDR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ADDR: begin
                // Expiry takes precedence over a byte landing in the same cycle
                if (expire) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (i_uart_valid) begin
                    addr_we = 1'b1;
                    if (idx_q == ADDR_LAST) begin
                        idx_d   = '0;
                        state_d = rnw_q ? MEM : DATA;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            DATA: begin
                if (expire) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (i_uart_valid) begin
                    data_we = 1'b1;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = MEM;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            MEM: begin
                o_mem_valid = 1'b1;
                err_d       = i_uart_valid;
                if (i_mem_accept) begin
                    resp_we = rnw_q;
                    idx_d   = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                o_uart_valid = 1'b1;
                o_uart_data  = rnw_q ? resp_q[{idx_q, 3'b000} +: 8] : ACK;
                err_d        = i_uart_valid;
                if (i_uart_accept) begin
                    if (idx_q == (rnw_q ? RD_RESP_LAST : WR_RESP_LAST)) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_mem_rnw  = rnw_q;
    assign o_mem_addr = addr_q;
    assign o_mem_data = data_q;
    assign o_err      = err_q;

endmodule
